jtframe_sdram_monitor: RTL and testbench
========================================

# jtframe_sdram_monitor

Synthesisable, parametrised SDRAM command-bus monitor for simulation and on-board debug. It sits beside the SDRAM controller and decodes the same pins driven to the chip. Per bank it counts ACTIVE, READ and WRITE commands, same-row re-activations and the longest same-row run over a fixed measurement window. Snapshots are exposed on a registered read port, and protocol violations are raised as sticky error flags.

## Interface
Parameters:
- BAW, 2, bank address width; the block monitors 2**BAW banks.
- RW, 13, row/address bus width.
- CW, 16, statistics counter width; all counters saturate at 2**CW-1.
- WINDOW, 48000, measurement window length in clk cycles (≥2).

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of counters, snapshots, errors and the window timer.
- sdram_a  in  RW  SDRAM address bus.
- sdram_ba  in  BAW  bank address.
- sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe  in  1 each  command pins.
- st_addr  in  BAW+3  statistics select, {bank, field[2:0]}.
- st_dout  out  CW  selected snapshot value, registered.
- win  out  1  one-cycle pulse when a new snapshot is latched.
- err  out  2**BAW  sticky per-bank protocol-error flags.

## Operation
- Decode cmd={ncs,nras,ncas,nwe} every clk; ncs=1 is an inhibit and is ignored.
- Valid codes: 0 LOAD_MODE, 1 REFRESH, 2 PRECHARGE, 3 ACTIVE, 4 WRITE, 5 READ, 6 STOP, 7 NOP.
- Per-bank state: open flag, last row (RW bits), row-valid flag, current run (CW), plus live counters act, rd, wr, same and longest.
- ACTIVE on bank b:
  - act_b++.
  - If row-valid and sdram_a==last row: same_b++ and run_b++.
  - Otherwise run_b=1 and last row=sdram_a.
  - Set row-valid and open.
  - longest_b=max(longest_b, new run_b). The updated run value is used, so a run of N consecutive same-row ACTIVEs gives longest=N.
  - If the bank was already open, set err[b].
- READ/WRITE on bank b: rd_b++ or wr_b++. If bank b is not open, set err[b].
- PRECHARGE: if sdram_a[10]=1, close all banks; otherwise close bank sdram_ba.
- REFRESH: refresh count++ (global). If any bank is open, set err of every open bank.
- LOAD_MODE, STOP and NOP: no effect.
- Window timer counts 0..WINDOW-1. On the terminal count:
  - Copy every live counter into its snapshot.
  - Reset live counters, including longest and run, to 0; row-valid is kept.
  - Increment the window index.
  - Pulse win.
- Field map for st_addr[2:0]:
  - 0 act, 1 rd, 2 wr, 3 same, 4 longest.
  - 5 refresh (global; bank bits ignored).
  - 6 err zero-extended (bank bits ignored).
  - 7 window index (wraps at 2**CW).
- Counters saturate: increment at 2**CW-1 holds the value.
- clr has priority over all command effects. It zeroes live counters, snapshots, err, the window timer, the window index, open flags and row-valid flags.

## Timing
- Reset (rst high, asynchronous): every output and internal register is 0, including st_dout, win, err, all flags and all counters.
- Commands are sampled on the rising clk edge; counters update on that edge.
- st_dout latency: 1 cycle after st_addr; it reflects snapshots as of the previous edge.
- win is high for exactly one cycle, on the cycle after the terminal-count edge. Snapshots are valid at the same time win rises.
- Window boundary coinciding with a command:
  - The command counts into the new window, so the live counter loads 1.
  - The snapshot excludes that command.
  - A same-row ACTIVE at the boundary starts run=1 in the new window.
- clr coinciding with a window terminal count: clr wins; no win pulse.
- rst asserted mid-window: everything returns to reset values immediately. After rst is released, the first window is a full WINDOW cycles.

## Test plan
- ACTIVE bank1 row 0x123 ×4 (PRECHARGE between each), READ ×3, WRITE ×2, WINDOW=100 -> after win: bank1 act=4, same=3, longest=4, rd=3, wr=2; other banks 0; err=0.
- READ to bank2 after reset with no ACTIVE -> err=4'b0100 and it stays set across windows until clr; a following ACTIVE/READ pair adds no new error.
- ACTIVE bank0 twice without PRECHARGE -> err[0]=1. PRECHARGE with A10=1 then ACTIVE on banks 0..3 -> no further errors.
- CW=4: 20 ACTIVEs on bank3 within one window -> act snapshot=15 (saturated).
- ACTIVE on the exact terminal-count cycle -> snapshot act=k (commands before the boundary); the next window's act includes that ACTIVE (≥1).
- Assert rst mid-window, then clr concurrent with the terminal count -> all outputs 0; no win pulse; window index=0; the next win arrives WINDOW cycles later.

Source files
------------

// File: rtl/jtframe_sdram_monitor.sv
// SDRAM command-bus monitor: per-bank ACTIVE/READ/WRITE/same-row statistics over a
// fixed window, snapshot read port and sticky per-bank protocol-error flags.
module jtframe_sdram_monitor #(
  parameter int BAW    = 2,
  parameter int RW     = 13,
  parameter int CW     = 16,
  parameter int WINDOW = 48000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [RW-1:0]         sdram_a,
  input  logic [BAW-1:0]        sdram_ba,
  input  logic                  sdram_ncs,
  input  logic                  sdram_nras,
  input  logic                  sdram_ncas,
  input  logic                  sdram_nwe,
  input  logic [BAW+2:0]        st_addr,
  output logic [CW-1:0]         st_dout,
  output logic                  win,
  output logic [(1<<BAW)-1:0]   err
);
  localparam int NB = 1 << BAW;
  localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0] WLAST = TW'(WINDOW - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [CW-1:0] act_q [NB], act_d [NB], rd_q [NB], rd_d [NB], wr_q [NB], wr_d [NB];
  logic [CW-1:0] same_q [NB], same_d [NB], lng_q [NB], lng_d [NB], run_q [NB], run_d [NB];
  logic [CW-1:0] s_act_q [NB], s_act_d [NB], s_rd_q [NB], s_rd_d [NB], s_wr_q [NB], s_wr_d [NB];
  logic [CW-1:0] s_same_q [NB], s_same_d [NB], s_lng_q [NB], s_lng_d [NB];
  logic [RW-1:0] row_q [NB], row_d [NB];
  logic [NB-1:0] open_q, open_d, rv_q, rv_d, err_q, err_d;
  logic [CW-1:0] ref_q, ref_d, s_ref_q, s_ref_d, widx_q, widx_d, dout_q, dout_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d, tc;
  logic [BAW-1:0] sel_bank;

  assign st_dout  = dout_q;
  assign win      = win_q;
  assign err      = err_q;
  assign sel_bank = st_addr[BAW+2:3];

  always_comb begin
    tc     = (cnt_q == WLAST);
    cnt_d  = tc ? '0 : cnt_q + TW'(1);
    win_d  = tc;
    widx_d = tc ? widx_q + CW'(1) : widx_q;
    open_d = open_q;
    rv_d   = rv_q;
    err_d  = err_q;
    ref_d  = tc ? '0 : ref_q;
    s_ref_d = tc ? ref_q : s_ref_q;
    for (int i = 0; i < NB; i++) begin
      row_d[i]    = row_q[i];
      s_act_d[i]  = tc ? act_q[i]  : s_act_q[i];
      s_rd_d[i]   = tc ? rd_q[i]   : s_rd_q[i];
      s_wr_d[i]   = tc ? wr_q[i]   : s_wr_q[i];
      s_same_d[i] = tc ? same_q[i] : s_same_q[i];
      s_lng_d[i]  = tc ? lng_q[i]  : s_lng_q[i];
      // boundary commands count into the fresh window, so live counters start from 0
      act_d[i]    = tc ? '0 : act_q[i];
      rd_d[i]     = tc ? '0 : rd_q[i];
      wr_d[i]     = tc ? '0 : wr_q[i];
      same_d[i]   = tc ? '0 : same_q[i];
      lng_d[i]    = tc ? '0 : lng_q[i];
      run_d[i]    = tc ? '0 : run_q[i];
    end
    if (!sdram_ncs) begin
      case ({sdram_nras, sdram_ncas, sdram_nwe})
        3'd1: begin
          ref_d = sat_inc(ref_d);
          err_d = err_d | open_q;
        end
        3'd2: begin
          if (sdram_a[10]) open_d = '0;
          else             open_d[sdram_ba] = 1'b0;
        end
        3'd3: begin
          act_d[sdram_ba] = sat_inc(act_d[sdram_ba]);
          if (rv_q[sdram_ba] && (sdram_a == row_q[sdram_ba])) begin
            same_d[sdram_ba] = sat_inc(same_d[sdram_ba]);
            run_d[sdram_ba]  = sat_inc(run_d[sdram_ba]);
          end else begin
            run_d[sdram_ba] = CW'(1);
            row_d[sdram_ba] = sdram_a;
          end
          if (run_d[sdram_ba] > lng_d[sdram_ba]) lng_d[sdram_ba] = run_d[sdram_ba];
          else                                   lng_d[sdram_ba] = lng_d[sdram_ba];
          rv_d[sdram_ba]   = 1'b1;
          open_d[sdram_ba] = 1'b1;
          if (open_q[sdram_ba]) err_d[sdram_ba] = 1'b1;
          else                  err_d[sdram_ba] = err_d[sdram_ba];
        end
        3'd4: begin
          wr_d[sdram_ba] = sat_inc(wr_d[sdram_ba]);
          if (!open_q[sdram_ba]) err_d[sdram_ba] = 1'b1;
          else                   err_d[sdram_ba] = err_d[sdram_ba];
        end
        3'd5: begin
          rd_d[sdram_ba] = sat_inc(rd_d[sdram_ba]);
          if (!open_q[sdram_ba]) err_d[sdram_ba] = 1'b1;
          else                   err_d[sdram_ba] = err_d[sdram_ba];
        end
        default: begin
        end
      endcase
    end
    if (clr) begin
      cnt_d = '0; win_d = 1'b0; widx_d = '0; open_d = '0; rv_d = '0; err_d = '0;
      ref_d = '0; s_ref_d = '0;
      for (int i = 0; i < NB; i++) begin
        act_d[i] = '0; rd_d[i] = '0; wr_d[i] = '0; same_d[i] = '0; lng_d[i] = '0; run_d[i] = '0;
        s_act_d[i] = '0; s_rd_d[i] = '0; s_wr_d[i] = '0; s_same_d[i] = '0; s_lng_d[i] = '0;
      end
    end else begin
      cnt_d = cnt_d;
    end
    case (st_addr[2:0])
      3'd0:    dout_d = s_act_q[sel_bank];
      3'd1:    dout_d = s_rd_q[sel_bank];
      3'd2:    dout_d = s_wr_q[sel_bank];
      3'd3:    dout_d = s_same_q[sel_bank];
      3'd4:    dout_d = s_lng_q[sel_bank];
      3'd5:    dout_d = s_ref_q;
      3'd6:    dout_d = CW'(err_q);
      3'd7:    dout_d = widx_q;
      default: dout_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0; win_q <= 1'b0; widx_q <= '0; open_q <= '0; rv_q <= '0; err_q <= '0;
      ref_q <= '0; s_ref_q <= '0; dout_q <= '0;
      for (int i = 0; i < NB; i++) begin
        act_q[i] <= '0; rd_q[i] <= '0; wr_q[i] <= '0; same_q[i] <= '0; lng_q[i] <= '0;
        run_q[i] <= '0; row_q[i] <= '0; s_act_q[i] <= '0; s_rd_q[i] <= '0; s_wr_q[i] <= '0;
        s_same_q[i] <= '0; s_lng_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d; win_q <= win_d; widx_q <= widx_d; open_q <= open_d; rv_q <= rv_d;
      err_q <= err_d; ref_q <= ref_d; s_ref_q <= s_ref_d; dout_q <= dout_d;
      for (int i = 0; i < NB; i++) begin
        act_q[i] <= act_d[i]; rd_q[i] <= rd_d[i]; wr_q[i] <= wr_d[i]; same_q[i] <= same_d[i];
        lng_q[i] <= lng_d[i]; run_q[i] <= run_d[i]; row_q[i] <= row_d[i];
        s_act_q[i] <= s_act_d[i]; s_rd_q[i] <= s_rd_d[i]; s_wr_q[i] <= s_wr_d[i];
        s_same_q[i] <= s_same_d[i]; s_lng_q[i] <= s_lng_d[i];
      end
    end
  end
endmodule

// File: tb/tb_jtframe_sdram_monitor.sv
// Directed bench for jtframe_sdram_monitor (BAW=2, CW=4, WINDOW=100).
module tb_jtframe_sdram_monitor;
  localparam int BAW = 2, RW = 13, CW = 4, WINDOW = 100;
  localparam logic [2:0] C_REF = 3'd1, C_PRE = 3'd2, C_ACT = 3'd3, C_WR = 3'd4, C_RD = 3'd5, C_NOP = 3'd7;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [RW-1:0] sdram_a = '0;
  logic [BAW-1:0] sdram_ba = '0;
  logic sdram_ncs = 1'b0, sdram_nras = 1'b1, sdram_ncas = 1'b1, sdram_nwe = 1'b1;
  logic [BAW+2:0] st_addr = '0;
  logic [CW-1:0] st_dout;
  logic win;
  logic [3:0] err;
  int errors = 0, checks = 0;
  logic [CW-1:0] v;
  logic ok;

  jtframe_sdram_monitor #(.BAW(BAW), .RW(RW), .CW(CW), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sdram_a(sdram_a), .sdram_ba(sdram_ba),
    .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
    .st_addr(st_addr), .st_dout(st_dout), .win(win), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cmd(input logic [2:0] code, input logic [1:0] ba, input logic [12:0] a);
    {sdram_nras, sdram_ncas, sdram_nwe} = code;
    sdram_ba = ba; sdram_a = a;
    @(posedge clk); #1;
    {sdram_nras, sdram_ncas, sdram_nwe} = C_NOP;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic read_stat(input logic [1:0] bank, input logic [2:0] field, output logic [CW-1:0] val);
    st_addr = {bank, field};
    @(posedge clk); #1;
    val = st_dout;
  endtask

  task automatic wait_win(output logic found);
    found = 1'b0;
    for (int i = 0; i < 3 * WINDOW; i++) begin
      @(negedge clk);
      if (win) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_win: win=0 after %0d cycles, required a pulse", 3 * WINDOW);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({st_dout, win, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: st_dout=%0d win=%0b err=%b, required 0", st_dout, win, err);
    end
    @(negedge clk); rst = 1'b0;
    read_stat(2'd0, 3'd7, v);
    checks++;
    if (v !== 4'd0) begin errors++; $display("FAIL reset_widx: got %0d, required 0", v); end
  endtask

  task automatic test_counts();
    do_clr();
    cmd(C_REF, 2'd0, 13'h000);
    for (int i = 0; i < 3; i++) begin
      cmd(C_ACT, 2'd1, 13'h123);
      cmd(C_PRE, 2'd1, 13'h000);
    end
    cmd(C_ACT, 2'd1, 13'h123);
    repeat (3) cmd(C_RD, 2'd1, 13'h000);
    repeat (2) cmd(C_WR, 2'd1, 13'h000);
    wait_win(ok);
    read_stat(2'd1, 3'd0, v);
    checks++; if (v !== 4'd4) begin errors++; $display("FAIL b1_act: got %0d, required 4", v); end
    read_stat(2'd1, 3'd3, v);
    checks++; if (v !== 4'd3) begin errors++; $display("FAIL b1_same: got %0d, required 3", v); end
    read_stat(2'd1, 3'd4, v);
    checks++; if (v !== 4'd4) begin errors++; $display("FAIL b1_longest: got %0d, required 4", v); end
    read_stat(2'd1, 3'd1, v);
    checks++; if (v !== 4'd3) begin errors++; $display("FAIL b1_rd: got %0d, required 3", v); end
    read_stat(2'd1, 3'd2, v);
    checks++; if (v !== 4'd2) begin errors++; $display("FAIL b1_wr: got %0d, required 2", v); end
    read_stat(2'd0, 3'd0, v);
    checks++; if (v !== 4'd0) begin errors++; $display("FAIL b0_act: got %0d, required 0", v); end
    read_stat(2'd2, 3'd1, v);
    checks++; if (v !== 4'd0) begin errors++; $display("FAIL b2_rd: got %0d, required 0", v); end
    read_stat(2'd3, 3'd5, v);
    checks++; if (v !== 4'd1) begin errors++; $display("FAIL refresh: got %0d, required 1", v); end
    read_stat(2'd0, 3'd7, v);
    checks++; if (v !== 4'd1) begin errors++; $display("FAIL widx: got %0d, required 1", v); end
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL counts_err: got %b, required 0000", err); end
    cmd(C_PRE, 2'd0, 13'h400);
  endtask

  task automatic test_err_read();
    do_clr();
    cmd(C_RD, 2'd2, 13'h000);
    checks++; if (err !== 4'b0100) begin errors++; $display("FAIL rd_closed_err: got %b, required 0100", err); end
    wait_win(ok);
    read_stat(2'd0, 3'd6, v);
    checks++; if (v !== 4'd4) begin errors++; $display("FAIL err_field: got %0d, required 4", v); end
    cmd(C_ACT, 2'd2, 13'h010);
    cmd(C_RD, 2'd2, 13'h000);
    checks++; if (err !== 4'b0100) begin errors++; $display("FAIL err_sticky: got %b, required 0100", err); end
    do_clr();
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL err_clr: got %b, required 0000", err); end
  endtask

  task automatic test_err_activate();
    do_clr();
    cmd(C_ACT, 2'd0, 13'h001);
    cmd(C_ACT, 2'd0, 13'h002);
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL double_act: got %b, required 0001", err); end
    cmd(C_PRE, 2'd0, 13'h400);
    for (int b = 0; b < 4; b++) cmd(C_ACT, b[1:0], 13'h005);
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL pre_all: got %b, required 0001", err); end
    cmd(C_REF, 2'd0, 13'h000);
    checks++; if (err !== 4'b1111) begin errors++; $display("FAIL ref_open: got %b, required 1111", err); end
    cmd(C_PRE, 2'd0, 13'h400);
  endtask

  task automatic test_saturation();
    do_clr();
    repeat (20) cmd(C_ACT, 2'd3, 13'h005);
    wait_win(ok);
    read_stat(2'd3, 3'd0, v);
    checks++; if (v !== 4'd15) begin errors++; $display("FAIL sat_act: got %0d, required 15", v); end
    read_stat(2'd3, 3'd4, v);
    checks++; if (v !== 4'd15) begin errors++; $display("FAIL sat_longest: got %0d, required 15", v); end
  endtask

  task automatic test_boundary();
    wait_win(ok);
    cmd(C_ACT, 2'd0, 13'h007);
    cmd(C_PRE, 2'd0, 13'h000);
    cmd(C_ACT, 2'd0, 13'h007);
    cmd(C_PRE, 2'd0, 13'h000);
    idle(WINDOW - 5);
    cmd(C_ACT, 2'd0, 13'h007);
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL bnd_win: got %0b, required 1", win); end
    read_stat(2'd0, 3'd0, v);
    checks++; if (v !== 4'd2) begin errors++; $display("FAIL bnd_snap_act: got %0d, required 2", v); end
    read_stat(2'd0, 3'd4, v);
    checks++; if (v !== 4'd2) begin errors++; $display("FAIL bnd_snap_longest: got %0d, required 2", v); end
    wait_win(ok);
    read_stat(2'd0, 3'd0, v);
    checks++; if (v !== 4'd1) begin errors++; $display("FAIL bnd_next_act: got %0d, required 1", v); end
    read_stat(2'd0, 3'd4, v);
    checks++; if (v !== 4'd1) begin errors++; $display("FAIL bnd_next_longest: got %0d, required 1", v); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL bnd_err0: got %0b, required 0", err[0]); end
  endtask

  task automatic test_rst_clr();
    int n;
    cmd(C_RD, 2'd1, 13'h000);
    checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL pre_rst_err: got %0b, required 1", err[1]); end
    st_addr = {2'd0, 3'd0};
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if ({st_dout, win, err} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: st_dout=%0d win=%0b err=%b, required 0", st_dout, win, err);
    end
    @(negedge clk); rst = 1'b0;
    idle(WINDOW - 1);
    do_clr();
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL clr_tc_win: got %0b, required 0", win); end
    read_stat(2'd0, 3'd7, v);
    checks++; if (v !== 4'd0) begin errors++; $display("FAIL clr_tc_widx: got %0d, required 0", v); end
    n = 1;
    for (int i = 0; i < 3 * WINDOW; i++) begin
      if (win) break;
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== WINDOW) begin errors++; $display("FAIL next_win_delay: got %0d cycles, required %0d", n, WINDOW); end
  endtask

  initial begin
    test_reset();
    test_counts();
    test_err_read();
    test_err_activate();
    test_saturation();
    test_boundary();
    test_rst_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
